// File: rtl/clint_if.sv
// Signal bundle between the core (decode/EX/CSR file) and the clint trap sequencer.
// The core drives the master side; the clint itself connects through the slave side.
interface clint_if #(
  parameter int INT_W = 8
);
  logic [INT_W-1:0] int_flag;
  logic [31:0]      inst;
  logic [31:0]      inst_addr;
  logic             jump_flag;
  logic [31:0]      jump_addr;
  logic             ex_busy;
  logic [31:0]      csr_mtvec;
  logic [31:0]      csr_mepc;
  logic [31:0]      csr_mstatus;
  logic             csr_we;
  logic [11:0]      csr_waddr;
  logic [31:0]      csr_wdata;
  logic             hold_flag_int;
  logic             int_assert;
  logic [31:0]      int_addr;

  modport slave (
    input  int_flag, inst, inst_addr, jump_flag, jump_addr, ex_busy,
    input  csr_mtvec, csr_mepc, csr_mstatus,
    output csr_we, csr_waddr, csr_wdata, hold_flag_int, int_assert, int_addr
  );

  modport master (
    output int_flag, inst, inst_addr, jump_flag, jump_addr, ex_busy,
    output csr_mtvec, csr_mepc, csr_mstatus,
    input  csr_we, csr_waddr, csr_wdata, hold_flag_int, int_assert, int_addr
  );
endinterface

// File: rtl/clint.sv
// Core-local interrupt/trap sequencer: freezes the pipeline, writes mepc/mstatus/mcause
// (or mstatus for mret), then redirects fetch. Define CLINT_ECALL_EN to decode ecall/ebreak.
module clint (
  input  logic     clk,
  input  logic     rst,
  clint_if.slave   bus
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] CAUSE_IRQ   = 32'h8000_000B;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_MRET,
    S_ASSERT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic        r_mret;

  logic        w_ecall;
  logic        w_ebreak;
  logic        w_sync;
  logic        w_async;
  logic        w_idle;
  logic        w_trap;
  logic        w_mret_take;
  logic [31:0] w_mstatus;
  logic [31:0] w_trap_pc;
  logic [31:0] w_trap_cause;

  logic        w_csr_we;
  logic [11:0] w_csr_waddr;
  logic [31:0] w_csr_wdata;
  logic        w_hold;
  logic        w_int_assert;
  logic [31:0] w_int_addr;

`ifdef CLINT_ECALL_EN
  assign w_ecall  = (bus.inst == INST_ECALL);
  assign w_ebreak = (bus.inst == INST_EBREAK);
`else
  assign w_ecall  = 1'b0;
  assign w_ebreak = 1'b0;
`endif

  assign w_mstatus = bus.csr_mstatus;
  assign w_sync    = w_ecall | w_ebreak;
  assign w_async   = (|bus.int_flag) & w_mstatus[3] & ~bus.ex_busy;
  // Reset also gates detection so hold drops the moment rst rises.
  assign w_idle      = (r_state == S_IDLE) & ~rst;
  assign w_trap      = w_idle & (w_sync | w_async);
  assign w_mret_take = w_idle & ~w_sync & ~w_async & (bus.inst == INST_MRET);

  // An async irq returns to the redirect target if EX is jumping, so it isn't lost.
  assign w_trap_pc = w_sync ? bus.inst_addr :
                     (bus.jump_flag ? bus.jump_addr : bus.inst_addr);

`ifdef CLINT_ECALL_EN
  assign w_trap_cause = w_ecall  ? 32'd11 :
                        w_ebreak ? 32'd3  : CAUSE_IRQ;
`else
  assign w_trap_cause = CAUSE_IRQ;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= 32'h0;
      r_cause <= 32'h0;
      r_mret  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_trap) begin
        r_pc    <= w_trap_pc;
        r_cause <= w_trap_cause;
        r_mret  <= 1'b0;
      end else if (w_mret_take) begin
        r_mret  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_csr_we     = 1'b0;
    w_csr_waddr  = 12'h0;
    w_csr_wdata  = 32'h0;
    w_hold       = 1'b1;
    w_int_assert = 1'b0;
    w_int_addr   = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_hold = w_trap | w_mret_take;
        if (w_trap) begin
          w_state_next = S_MEPC;
        end else if (w_mret_take) begin
          w_state_next = S_MRET;
        end
      end
      S_MEPC: begin
        w_csr_we     = 1'b1;
        w_csr_waddr  = ADDR_MEPC;
        w_csr_wdata  = r_pc;
        w_state_next = S_MSTATUS;
      end
      S_MSTATUS: begin
        w_csr_we     = 1'b1;
        w_csr_waddr  = ADDR_MSTATUS;
        w_csr_wdata  = {w_mstatus[31:8], w_mstatus[3], w_mstatus[6:4], 1'b0, w_mstatus[2:0]};
        w_state_next = S_MCAUSE;
      end
      S_MCAUSE: begin
        w_csr_we     = 1'b1;
        w_csr_waddr  = ADDR_MCAUSE;
        w_csr_wdata  = r_cause;
        w_state_next = S_ASSERT;
      end
      S_MRET: begin
        w_csr_we     = 1'b1;
        w_csr_waddr  = ADDR_MSTATUS;
        w_csr_wdata  = {w_mstatus[31:8], 1'b1, w_mstatus[6:4], w_mstatus[7], w_mstatus[2:0]};
        w_state_next = S_ASSERT;
      end
      S_ASSERT: begin
        w_int_assert = 1'b1;
        w_int_addr   = r_mret ? bus.csr_mepc : bus.csr_mtvec;
        w_state_next = S_IDLE;
      end
      default: begin
        w_hold       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.csr_we        = w_csr_we;
  assign bus.csr_waddr     = w_csr_waddr;
  assign bus.csr_wdata     = w_csr_wdata;
  assign bus.hold_flag_int = w_hold;
  assign bus.int_assert    = w_int_assert;
  assign bus.int_addr      = w_int_addr;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: each task drives one scenario and checks every cycle's outputs
// packed as {hold, csr_we, csr_waddr, csr_wdata, int_assert, int_addr}.
module tb_clint;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] IRQC  = 32'h8000_000B;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  clint_if #(.INT_W(8)) ifc ();

  clint u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [78:0] obs;
  assign obs = {ifc.hold_flag_int, ifc.csr_we, ifc.csr_waddr, ifc.csr_wdata,
                ifc.int_assert, ifc.int_addr};

  function automatic logic [78:0] ex(input logic h, input logic we, input logic [11:0] a,
                                     input logic [31:0] d, input logic as, input logic [31:0] ia);
    return {h, we, a, d, as, ia};
  endfunction

  task automatic drive_idle;
    ifc.int_flag    = 8'h00;
    ifc.inst        = NOP;
    ifc.inst_addr   = 32'h0;
    ifc.jump_flag   = 1'b0;
    ifc.jump_addr   = 32'h0;
    ifc.ex_busy     = 1'b0;
    ifc.csr_mtvec   = 32'h200;
    ifc.csr_mepc    = 32'h0;
    ifc.csr_mstatus = 32'h8;
  endtask

  task automatic test_reset;
    drive_idle();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 79'h0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want %h", obs, 79'h0);
    end
    ifc.inst = ECALL;
    ifc.int_flag = 8'h01;
    #1;
    n_cmp++;
    if (obs !== 79'h0) begin
      n_bad++;
      $display("FAIL reset_gated: got %h want %h", obs, 79'h0);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== 79'h0) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", obs, 79'h0);
    end
  endtask

`ifdef CLINT_ECALL_EN
  task automatic test_sync(input logic [31:0] ins, input logic [31:0] cause, input string nm);
    logic [78:0] e_tab [6];
    e_tab[0] = ex(1, 0, 12'h0,   32'h0,   0, 32'h0);
    e_tab[1] = ex(1, 1, 12'h341, 32'h100, 0, 32'h0);
    e_tab[2] = ex(1, 1, 12'h300, 32'h80,  0, 32'h0);
    e_tab[3] = ex(1, 1, 12'h342, cause,   0, 32'h0);
    e_tab[4] = ex(1, 0, 12'h0,   32'h0,   1, 32'h200);
    e_tab[5] = ex(0, 0, 12'h0,   32'h0,   0, 32'h0);
    @(negedge clk);
    ifc.inst = ins; ifc.inst_addr = 32'h100; ifc.csr_mstatus = 32'h8; ifc.csr_mtvec = 32'h200;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) ifc.inst = NOP;
      #1;
      n_cmp++;
      if (obs !== e_tab[c]) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got %h want %h", nm, c, obs, e_tab[c]);
      end
    end
    drive_idle();
  endtask
`else
  task automatic test_sync(input logic [31:0] ins, input logic [31:0] cause, input string nm);
    @(negedge clk);
    ifc.inst = ins; ifc.inst_addr = 32'h100 + cause;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (obs !== 79'h0) begin
        n_bad++;
        $display("FAIL %s_ignored cyc%0d: got %h want %h", nm, c, obs, 79'h0);
      end
    end
    drive_idle();
  endtask
`endif

  task automatic test_irq_jump;
    logic [78:0] e_tab [6];
    e_tab[0] = ex(1, 0, 12'h0,   32'h0,    0, 32'h0);
    e_tab[1] = ex(1, 1, 12'h341, 32'h340,  0, 32'h0);
    e_tab[2] = ex(1, 1, 12'h300, 32'h1880, 0, 32'h0);
    e_tab[3] = ex(1, 1, 12'h342, IRQC,     0, 32'h0);
    e_tab[4] = ex(1, 0, 12'h0,   32'h0,    1, 32'h240);
    e_tab[5] = ex(0, 0, 12'h0,   32'h0,    0, 32'h0);
    @(negedge clk);
    ifc.int_flag = 8'h01; ifc.csr_mstatus = 32'h1888; ifc.csr_mtvec = 32'h240;
    ifc.jump_flag = 1'b1; ifc.jump_addr = 32'h340; ifc.inst_addr = 32'h120;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin
        ifc.int_flag = 8'h00; ifc.jump_flag = 1'b0; ifc.jump_addr = 32'h0;
      end
      #1;
      n_cmp++;
      if (obs !== e_tab[c]) begin
        n_bad++;
        $display("FAIL irq_jump cyc%0d: got %h want %h", c, obs, e_tab[c]);
      end
    end
    drive_idle();
  endtask

  task automatic test_irq_masked;
    logic [78:0] e_tab [9];
    for (int c = 0; c < 4; c++) e_tab[c] = 79'h0;
    e_tab[4] = ex(1, 0, 12'h0,   32'h0,   0, 32'h0);
    e_tab[5] = ex(1, 1, 12'h341, 32'h150, 0, 32'h0);
    e_tab[6] = ex(1, 1, 12'h300, 32'h80,  0, 32'h0);
    e_tab[7] = ex(1, 1, 12'h342, IRQC,    0, 32'h0);
    e_tab[8] = ex(1, 0, 12'h0,   32'h0,   1, 32'h200);
    @(negedge clk);
    ifc.int_flag = 8'h80; ifc.csr_mstatus = 32'h0; ifc.inst_addr = 32'h150;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin ifc.csr_mstatus = 32'h8; ifc.ex_busy = 1'b1; end
      if (c == 4) ifc.ex_busy = 1'b0;
      if (c == 6) ifc.int_flag = 8'h00;
      #1;
      n_cmp++;
      if (obs !== e_tab[c]) begin
        n_bad++;
        $display("FAIL irq_masked cyc%0d: got %h want %h", c, obs, e_tab[c]);
      end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_mret(input logic [31:0] ms, input logic [31:0] wd, input string nm);
    logic [78:0] e_tab [4];
    e_tab[0] = ex(1, 0, 12'h0,   32'h0, 0, 32'h0);
    e_tab[1] = ex(1, 1, 12'h300, wd,    0, 32'h0);
    e_tab[2] = ex(1, 0, 12'h0,   32'h0, 1, 32'h104);
    e_tab[3] = ex(0, 0, 12'h0,   32'h0, 0, 32'h0);
    @(negedge clk);
    ifc.inst = MRET; ifc.csr_mstatus = ms; ifc.csr_mepc = 32'h104; ifc.inst_addr = 32'h2F0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) ifc.inst = NOP;
      #1;
      n_cmp++;
      if (obs !== e_tab[c]) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got %h want %h", nm, c, obs, e_tab[c]);
      end
    end
    drive_idle();
  endtask

  task automatic test_sync_and_irq;
    logic [31:0] cause;
    logic [78:0] e_want;
`ifdef CLINT_ECALL_EN
    cause = 32'd11;
`else
    cause = IRQC;
`endif
    @(negedge clk);
    ifc.inst = ECALL; ifc.int_flag = 8'h04; ifc.csr_mstatus = 32'h8; ifc.inst_addr = 32'h1A0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin ifc.inst = NOP; ifc.int_flag = 8'h00; end
      if (c == 3) begin
        e_want = ex(1, 1, 12'h342, cause, 0, 32'h0);
        #1;
        n_cmp++;
        if (obs !== e_want) begin
          n_bad++;
          $display("FAIL sync_and_irq mcause: got %h want %h", obs, e_want);
        end
      end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ifc.int_flag = 8'h01; ifc.inst_addr = 32'h1C0; ifc.csr_mstatus = 32'h8;
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== ex(1, 1, 12'h341, 32'h1C0, 0, 32'h0)) begin
      n_bad++;
      $display("FAIL reset_mid_mepc: got %h want %h", obs, ex(1, 1, 12'h341, 32'h1C0, 0, 32'h0));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 79'h0) begin
      n_bad++;
      $display("FAIL reset_mid_abort: got %h want %h", obs, 79'h0);
    end
    @(negedge clk);
    ifc.int_flag = 8'h00;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (obs !== 79'h0) begin
        n_bad++;
        $display("FAIL reset_mid_after cyc%0d: got %h want %h", c, obs, 79'h0);
      end
    end
    drive_idle();
  endtask

  task automatic test_back_to_back;
    logic [78:0] e_tab [11];
    e_tab[0]  = ex(1, 0, 12'h0,   32'h0,   0, 32'h0);
    e_tab[1]  = ex(1, 1, 12'h341, 32'h180, 0, 32'h0);
    e_tab[2]  = ex(1, 1, 12'h300, 32'h80,  0, 32'h0);
    e_tab[3]  = ex(1, 1, 12'h342, IRQC,    0, 32'h0);
    e_tab[4]  = ex(1, 0, 12'h0,   32'h0,   1, 32'h200);
    e_tab[5]  = ex(1, 0, 12'h0,   32'h0,   0, 32'h0);
    e_tab[6]  = ex(1, 1, 12'h341, 32'h184, 0, 32'h0);
    e_tab[7]  = ex(1, 1, 12'h300, 32'h80,  0, 32'h0);
    e_tab[8]  = ex(1, 1, 12'h342, IRQC,    0, 32'h0);
    e_tab[9]  = ex(1, 0, 12'h0,   32'h0,   1, 32'h200);
    e_tab[10] = ex(0, 0, 12'h0,   32'h0,   0, 32'h0);
    @(negedge clk);
    ifc.int_flag = 8'h10; ifc.csr_mstatus = 32'h8; ifc.inst_addr = 32'h180;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) ifc.inst_addr = 32'h184;
      if (c == 6) ifc.int_flag = 8'h00;
      #1;
      n_cmp++;
      if (obs !== e_tab[c]) begin
        n_bad++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", c, obs, e_tab[c]);
      end
    end
    drive_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_sync(ECALL, 32'd11, "ecall");
    test_sync(EBRK, 32'd3, "ebreak");
    test_irq_jump();
    test_irq_masked();
    test_mret(32'h80, 32'h88, "mret_mpie1");
    test_mret(32'h1800, 32'h1880, "mret_mpie0");
    test_sync_and_irq();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clint.md
# clint

Core-local interrupt and trap sequencer for the pipelined RV32 core. It sits directly upstream of the pipeline control block and feeds it `hold_flag_int`. It detects `ecall`/`ebreak`/`mret` in decode and level external interrupts, freezes the pipeline, and performs the mepc/mstatus/mcause CSR write sequence. It then redirects fetch to `mtvec` (on a trap) or `mepc` (on `mret`).

## Interface
- `INT_W`, 8, number of external interrupt request lines.

- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `int_flag`  in  INT_W  level interrupt requests; any bit set = pending.
- `inst`  in  32  instruction currently in decode.
- `inst_addr`  in  32  PC of `inst`.
- `jump_flag`  in  1  EX is redirecting this cycle.
- `jump_addr`  in  32  EX redirect target.
- `ex_busy`  in  1  EX multi-cycle op in flight.
- `csr_mtvec`  in  32  current mtvec.
- `csr_mepc`  in  32  current mepc.
- `csr_mstatus`  in  32  current mstatus; bit 3 = MIE, bit 7 = MPIE.
- `csr_we`  out  1  CSR write strobe.
- `csr_waddr`  out  12  CSR write address.
- `csr_wdata`  out  32  CSR write data.
- `hold_flag_int`  out  1  pipeline freeze request to ctrl.
- `int_assert`  out  1  one-cycle fetch redirect.
- `int_addr`  out  32  redirect target, valid with `int_assert`.

## Operation
- Decode, in priority order:
  - sync trap: `inst` == 0x00000073 (ecall, cause 11) or 0x00100073 (ebreak, cause 3);
  - async: `|int_flag` && `csr_mstatus[3]` && !`ex_busy` (cause 0x8000000B);
  - mret: `inst` == 0x30200073.
- At detection, latch:
  - return PC: sync → `inst_addr`; async → `jump_addr` if `jump_flag`, else `inst_addr`;
  - cause.
- States: IDLE → MEPC → MSTATUS → MCAUSE → ASSERT → IDLE for traps; IDLE → MRET → ASSERT → IDLE for mret.
- MEPC: `csr_we`=1, addr 0x341, data = latched PC.
- MSTATUS (trap): addr 0x300, data = `csr_mstatus` with bit7 ← bit3 and bit3 ← 0.
- MCAUSE: addr 0x342, data = latched cause.
- MRET: addr 0x300, data = `csr_mstatus` with bit3 ← bit7 and bit7 ← 1.
- ASSERT:
  - `int_assert`=1, `csr_we`=0;
  - `int_addr` = `csr_mtvec` (trap) or `csr_mepc` (mret).
- `csr_we` is 0 in IDLE and ASSERT; `csr_waddr`/`csr_wdata` are 0 when `csr_we`=0.
- No new detection outside IDLE. A trap sequence always completes even if `int_flag` drops mid-sequence.
- Simultaneous sync trap + async: sync is taken. The irq stays pending (level) but is masked by MIE=0 until software re-enables it.
- Async with `ex_busy`=1 stays pending; no hold is raised for it until it is taken.

## Timing
- Detection cycle N:
  - `hold_flag_int`=1 combinationally in N;
  - registered state advances at edge N+1.
- Trap:
  - CSR writes at N+1 (mepc), N+2 (mstatus), N+3 (mcause);
  - `int_assert` at N+4;
  - `hold_flag_int`=1 for N..N+4 inclusive.
- Mret:
  - write at N+1, `int_assert` at N+2;
  - hold for N..N+2.
- Downstream PC logic gives `int_assert` priority over hold.
- Reset:
  - all outputs 0, state IDLE, latches 0;
  - asserting `rst` mid-sequence aborts immediately with no further CSR writes.
- Back-to-back: the earliest next detection is the cycle after ASSERT.

## Configuration
- `CLINT_ECALL_EN` defined: ecall/ebreak raise sync traps as above.
- Undefined: ecall/ebreak are not decoded (treated as nops by this block). Only async interrupts and mret are handled, and the cause latch holds only 0x8000000B.

## Test plan
- Ecall with `inst_addr`=0x100, mtvec=0x200, mstatus=0x8 → writes (0x341,0x100), (0x300,0x80), (0x342,11) on N+1..N+3; `int_assert`, `int_addr`=0x200 at N+4; hold N..N+4.
- `int_flag`=0x01, MIE=1, `jump_flag`=1, `jump_addr`=0x340 → mepc write 0x340, mcause 0x8000000B.
- Irq with MIE=0, or with `ex_busy`=1 → no hold and no writes; taken the first cycle `ex_busy` falls with MIE=1.
- Mret with mstatus=0x80, mepc=0x104 → write (0x300,0x88) at N+1; `int_addr`=0x104 at N+2.
- Ecall and irq same cycle → mcause 11. `rst` pulsed at N+2 → `csr_we`=0 and `hold_flag_int`=0 from the reset assertion onward.
